// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter
//   Round-robin arbiter sharing one mpadder (WIDTH-bit add/sub, start/done
//   handshake) between two requesters. Each requester owns a one-deep slot;
//   one operation is in flight at a time, with operands held stable until
//   the adder reports done. Results return on a shared registered bus with a
//   per-requester one-cycle done pulse.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   reqN_start/_subtract/_a/_b      request pulse, op select and operands
//   reqN_busy                       slot N pending or in flight
//   reqN_done                       resp_result belongs to requester N
//   resp_result                     result of last completed operation
//   add_start/_subtract/_in_a/_in_b drive to mpadder
//   add_result, add_done            from mpadder
module mpadder_arbiter #(
    parameter int WIDTH = 1027
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_start,
    input  logic             req0_subtract,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_busy,
    output logic             req0_done,
    input  logic             req1_start,
    input  logic             req1_subtract,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_busy,
    output logic             req1_done,
    output logic [WIDTH:0]   resp_result,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;            // next-preferred requester id
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       sub_q, sub_d;
    logic [WIDTH-1:0] slot_a_q [2];
    logic [WIDTH-1:0] slot_a_d [2];
    logic [WIDTH-1:0] slot_b_q [2];
    logic [WIDTH-1:0] slot_b_d [2];
    logic             add_start_q, add_start_d;
    logic             add_sub_q, add_sub_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH:0]   resp_q, resp_d;
    logic [1:0]       done_q, done_d;

    logic [1:0]       start_v, sub_v, busy;
    logic [WIDTH-1:0] a_v [2];
    logic [WIDTH-1:0] b_v [2];
    logic             gnt_vld, gnt_id;

    assign start_v = {req1_start, req0_start};
    assign sub_v   = {req1_subtract, req0_subtract};
    assign a_v[0]  = req0_a;
    assign a_v[1]  = req1_a;
    assign b_v[0]  = req0_b;
    assign b_v[1]  = req1_b;

    // pend stays set through the whole operation; the owner term is kept so
    // busy reads correctly even if that invariant is ever relaxed.
    assign busy[0] = pend_q[0] | (state_q == S_WAIT && owner_q == 1'b0);
    assign busy[1] = pend_q[1] | (state_q == S_WAIT && owner_q == 1'b1);

    // Single pending slot wins outright; on a tie the rr pointer decides.
    assign gnt_vld = |pend_q;
    assign gnt_id  = (&pend_q) ? rr_q : pend_q[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        pend_d      = pend_q;
        sub_d       = sub_q;
        slot_a_d    = slot_a_q;
        slot_b_d    = slot_b_q;
        add_start_d = 1'b0;
        add_sub_d   = add_sub_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        resp_d      = resp_q;
        done_d      = 2'b00;

        // A start while busy is dropped so the slot keeps its operands.
        for (int n = 0; n < 2; n++) begin
            if (start_v[n] && !busy[n]) begin
                pend_d[n]   = 1'b1;
                sub_d[n]    = sub_v[n];
                slot_a_d[n] = a_v[n];
                slot_b_d[n] = b_v[n];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    add_a_d     = slot_a_q[gnt_id];
                    add_b_d     = slot_b_q[gnt_id];
                    add_sub_d   = sub_q[gnt_id];
                    add_start_d = 1'b1;
                    owner_d     = gnt_id;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (add_done) begin
                    resp_d          = add_result;
                    done_d[owner_q] = 1'b1;
                    pend_d[owner_q] = 1'b0;
                    rr_d            = ~owner_q;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            pend_q      <= 2'b00;
            sub_q       <= 2'b00;
            slot_a_q    <= '{default: '0};
            slot_b_q    <= '{default: '0};
            add_start_q <= 1'b0;
            add_sub_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            resp_q      <= '0;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            pend_q      <= pend_d;
            sub_q       <= sub_d;
            slot_a_q    <= slot_a_d;
            slot_b_q    <= slot_b_d;
            add_start_q <= add_start_d;
            add_sub_q   <= add_sub_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            resp_q      <= resp_d;
            done_q      <= done_d;
        end
    end

    assign req0_busy    = busy[0];
    assign req1_busy    = busy[1];
    assign req0_done    = done_q[0];
    assign req1_done    = done_q[1];
    assign resp_result  = resp_q;
    assign add_start    = add_start_q;
    assign add_subtract = add_sub_q;
    assign add_in_a     = add_a_q;
    assign add_in_b     = add_b_q;

endmodule

// File: doc/mpadder_arbiter.md
Name: mpadder_arbiter

Overview:
Round-robin arbiter that shares one mpadder instance (WIDTH-bit add/subtract, start/done handshake) between two requesters, e.g. the Montgomery loop and the final-subtraction/exponentiation controller.
- Each requester has a one-deep pending slot.
- The arbiter issues one operation at a time to the adder and holds its operands stable until done.
- It returns the result on a shared bus with a per-requester done pulse.

Parameters:
WIDTH, 1027, operand width of mpadder; result width is WIDTH+1.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
req0_start  input  1  one-cycle request pulse from requester 0; operands valid in the same cycle
req0_subtract  input  1  requester 0 op select: 0 = a+b, 1 = a-b
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_busy  output  1  requester 0 has a pending or in-flight operation
req0_done  output  1  one-cycle pulse: resp_result belongs to requester 0
req1_start, req1_subtract, req1_a, req1_b, req1_busy, req1_done  same as requester 0, for requester 1
resp_result  output  WIDTH+1  registered adder result of the last completed operation
add_start  output  1  one-cycle start pulse to mpadder
add_subtract  output  1  to mpadder subtract
add_in_a  output  WIDTH  to mpadder in_a
add_in_b  output  WIDTH  to mpadder in_b
add_result  input  WIDTH+1  from mpadder result
add_done  input  1  from mpadder done; result valid in the cycle done is high

Behaviour:
- Reset (async, resetn=0):
  - State=IDLE; pending0/1=0; rr pointer=0 (requester 0 favoured).
  - All outputs 0, including add_in_a/b and resp_result.
  - Reset mid-operation abandons the operation with no done pulse; mpadder shares resetn.
- Pending capture:
  - reqN_start=1 while reqN_busy=0 → on that edge pendingN<=1, and operands/subtract are latched into slot N.
  - reqN_start while reqN_busy=1 is ignored: no state change, slot contents preserved.
- reqN_busy = pendingN OR (in-flight owner==N). It is cleared on the same edge reqN_done is set, so a start in the done cycle is accepted.
- FSM states are IDLE and WAIT.
- IDLE:
  - If any slot is pending, grant it:
    - One pending slot: that one.
    - Both pending: the requester that was NOT served last. The rr pointer holds the next-preferred id.
  - On grant, the next edge does all of the following:
    - Slot N operands go to add_in_a, add_in_b, add_subtract.
    - add_start<=1, owner<=N, state<=WAIT.
  - reqN_done outputs are 0 in IDLE after the pulse cycle.
- WAIT:
  - add_start<=0 after one cycle, so it is exactly a one-cycle pulse.
  - add_in_a, add_in_b, add_subtract are held stable for the entire WAIT.
  - On add_done=1, the next edge does all of the following:
    - resp_result<=add_result; req[owner]_done<=1 for exactly one cycle.
    - pending[owner]<=0; rr pointer<=other id; state<=IDLE.
- Timing:
  - A pending slot granted in the IDLE cycle that coincides with a done pulse issues add_start on the following edge. Back-to-back alternation therefore costs 1 idle cycle between operations.
  - Minimum latency: reqN_start at cycle c → add_start high at c+2 → reqN_done high 1 cycle after add_done.
- add_done outside WAIT is ignored.
- resp_result holds its value until the next completion.
- Arithmetic is pass-through: no width change, and the carry/borrow bit WIDTH is preserved.
- Fairness: with both requesters continuously re-requesting, grants strictly alternate.

Test Plan:
- Single add: req0 with a=1, b=1, subtract=0 →
  - add_start one pulse at c+2, with add_in_a=add_in_b=1.
  - req0_done one pulse; resp_result=2; req1_done stays 0.
- Subtract with borrow: req1 with a=1, b=2, subtract=1 → req1_done pulse; resp_result = all ones (WIDTH+1 bits); req1_busy falls in the same cycle.
- Simultaneous starts after reset: req0 (a=5, b=3, add) and req1 (a=5, b=3, sub) in the same cycle →
  - req0 served first with resp_result=8.
  - Then req1 with resp_result=2.
  - Exactly one add_start per operation.
- Fairness: both requesters re-issue a start in every done cycle for 8 operations → grant order 0,1,0,1,…; no starvation; busy never drops for a requester that is waiting.
- Start while busy: req0_start pulsed again during WAIT with different operands → ignored; one operation only; original result returned.
- Reset mid-WAIT: assert resetn=0 two cycles after add_start → all outputs 0 immediately; after release, no done pulse and busy=0; a new request completes normally.
